// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants: ctrl bit map, bubble value, instruction field slices
package pipe_pkg;

  localparam int CTRL_W = 8;

  localparam int CTRL_REGDST   = 0;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_PCTOREG  = 6;
  localparam int CTRL_JR       = 7;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  typedef enum logic [1:0] {
    UPD_LOAD   = 2'd0,
    UPD_HOLD   = 2'd1,
    UPD_BUBBLE = 2'd2
  } upd_e;

  // Hold beats flush, flush/load-use beat a normal load; reset is handled at the flop.
  function automatic upd_e select_update(input logic hold, input logic flush,
                                         input logic load_use);
    if (hold) begin
      return UPD_HOLD;
    end
    if (flush || load_use) begin
      return UPD_BUBBLE;
    end
    return UPD_LOAD;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard detection between the EX load and the ID instruction
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       flush,
  output logic       load_use,
  output logic       stall
);

  // A bubble has valid=0 and MemRead=0, so it can never raise a stall.
  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (ex_rt == id_rt));
    stall    = load_use && !flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
// Optional stall counter output enabled by macro ID_EX_STALL_CNT_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic [31:0]       IF_ID_instr,
  input  logic [DW-1:0]     IF_ID_pc_add_out,
  input  logic [DW-1:0]     regfile_out1,
  input  logic [DW-1:0]     regfile_out2,
  input  logic [DW-1:0]     ext,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              stall,
  output logic              ID_EX_valid,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic [DW-1:0]     ID_EX_pc_add_out,
  output logic [DW-1:0]     ID_EX_regfile_out1,
  output logic [DW-1:0]     ID_EX_regfile_out2,
  output logic [DW-1:0]     ID_EX_ext,
  output logic [4:0]        ID_EX_rs,
  output logic [4:0]        ID_EX_rt,
  output logic [4:0]        ID_EX_rd,
`ifdef ID_EX_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [5:0]        ID_EX_funct
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0]     pc_q, pc_d;
  logic [DW-1:0]     rd1_q, rd1_d;
  logic [DW-1:0]     rd2_q, rd2_d;
  logic [DW-1:0]     ext_q, ext_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        rd_q, rd_d;
  logic [5:0]        funct_q, funct_d;

  logic [4:0] id_rs, id_rt, id_rd;
  logic [5:0] id_funct;
  logic       load_use;
  upd_e       upd;
  logic       unused_instr_bits;

  assign id_rs    = IF_ID_instr[RS_HI:RS_LO];
  assign id_rt    = IF_ID_instr[RT_HI:RT_LO];
  assign id_rd    = IF_ID_instr[RD_HI:RD_LO];
  assign id_funct = IF_ID_instr[FUNCT_HI:FUNCT_LO];
  assign unused_instr_bits = ^{IF_ID_instr[31:26], IF_ID_instr[10:6]};

  hazard_detect u_hazard_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q[CTRL_MEMREAD]),
    .ex_rt       (rt_q),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .flush       (flush),
    .load_use    (load_use),
    .stall       (stall)
  );

  always_comb begin
    upd     = select_update(hold, flush, load_use);
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    ext_d   = ext_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    funct_d = funct_q;
    case (upd)
      UPD_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_BUBBLE;
        pc_d    = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        ext_d   = '0;
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        funct_d = '0;
      end
      UPD_LOAD: begin
        valid_d = 1'b1;
        ctrl_d  = ctrl_in;
        pc_d    = IF_ID_pc_add_out;
        rd1_d   = regfile_out1;
        rd2_d   = regfile_out2;
        ext_d   = ext;
        rs_d    = id_rs;
        rt_d    = id_rt;
        rd_d    = id_rd;
        funct_d = id_funct;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      ext_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      funct_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      ext_q   <= ext_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      funct_q <= funct_d;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count only edges where the stall actually takes effect, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign ID_EX_valid        = valid_q;
  assign ID_EX_ctrl         = ctrl_q;
  assign ID_EX_pc_add_out   = pc_q;
  assign ID_EX_regfile_out1 = rd1_q;
  assign ID_EX_regfile_out2 = rd2_q;
  assign ID_EX_ext          = ext_q;
  assign ID_EX_rs           = rs_q;
  assign ID_EX_rt           = rt_q;
  assign ID_EX_rd           = rd_q;
  assign ID_EX_funct        = funct_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        flush;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc_add_out;
  logic [31:0] regfile_out1;
  logic [31:0] regfile_out2;
  logic [31:0] ext;
  logic [7:0]  ctrl_in;
  logic        stall;
  logic        ID_EX_valid;
  logic [7:0]  ID_EX_ctrl;
  logic [31:0] ID_EX_pc_add_out;
  logic [31:0] ID_EX_regfile_out1;
  logic [31:0] ID_EX_regfile_out2;
  logic [31:0] ID_EX_ext;
  logic [4:0]  ID_EX_rs;
  logic [4:0]  ID_EX_rt;
  logic [4:0]  ID_EX_rd;
  logic [5:0]  ID_EX_funct;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks;
  int failures;

  id_ex_stage #(.DW(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .hold               (hold),
    .flush              (flush),
    .IF_ID_instr        (IF_ID_instr),
    .IF_ID_pc_add_out   (IF_ID_pc_add_out),
    .regfile_out1       (regfile_out1),
    .regfile_out2       (regfile_out2),
    .ext                (ext),
    .ctrl_in            (ctrl_in),
    .stall              (stall),
    .ID_EX_valid        (ID_EX_valid),
    .ID_EX_ctrl         (ID_EX_ctrl),
    .ID_EX_pc_add_out   (ID_EX_pc_add_out),
    .ID_EX_regfile_out1 (ID_EX_regfile_out1),
    .ID_EX_regfile_out2 (ID_EX_regfile_out2),
    .ID_EX_ext          (ID_EX_ext),
    .ID_EX_rs           (ID_EX_rs),
    .ID_EX_rt           (ID_EX_rt),
    .ID_EX_rd           (ID_EX_rd),
`ifdef ID_EX_STALL_CNT_EN
    .stall_cnt          (stall_cnt),
`endif
    .ID_EX_funct        (ID_EX_funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of what the EX stage should hold.
  int unsigned m_valid, m_ctrl, m_pc, m_r1, m_r2, m_ext, m_rs, m_rt, m_rd, m_funct;
  int unsigned m_cnt;

  localparam int unsigned MEMREAD = 32'h10;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned field(input int unsigned v, input int sh, input int unsigned mask);
    return (v >> sh) & mask;
  endfunction

  function automatic logic model_stall();
    int unsigned src1, src2;
    src1 = field(IF_ID_instr, 21, 31);
    src2 = field(IF_ID_instr, 16, 31);
    return (m_valid == 1) && ((m_ctrl & MEMREAD) != 0) && (m_rt != 0) &&
           (m_rt == src1 || m_rt == src2) && !flush;
  endfunction

  task automatic model_zero();
    m_valid = 0; m_ctrl = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_ext = 0;
    m_rs = 0; m_rt = 0; m_rd = 0; m_funct = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(ID_EX_valid), 64'(m_valid));
    check({tag, ".ctrl"},  64'(ID_EX_ctrl),  64'(m_ctrl));
    check({tag, ".pc"},    64'(ID_EX_pc_add_out), 64'(m_pc));
    check({tag, ".r1"},    64'(ID_EX_regfile_out1), 64'(m_r1));
    check({tag, ".r2"},    64'(ID_EX_regfile_out2), 64'(m_r2));
    check({tag, ".ext"},   64'(ID_EX_ext), 64'(m_ext));
    check({tag, ".rs"},    64'(ID_EX_rs), 64'(m_rs));
    check({tag, ".rt"},    64'(ID_EX_rt), 64'(m_rt));
    check({tag, ".rd"},    64'(ID_EX_rd), 64'(m_rd));
    check({tag, ".funct"}, 64'(ID_EX_funct), 64'(m_funct));
`ifdef ID_EX_STALL_CNT_EN
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
`endif
  endtask

  // Inputs are already applied; check stall, clock once, advance model, check registers.
  task automatic step(input string tag);
    logic exp_stall;
    logic lu;
    #1;
    exp_stall = model_stall();
    lu = exp_stall || ((m_valid == 1) && ((m_ctrl & MEMREAD) != 0) && (m_rt != 0) &&
         (m_rt == field(IF_ID_instr, 21, 31) || m_rt == field(IF_ID_instr, 16, 31)));
    if (rst_n) check({tag, ".stall"}, 64'(stall), 64'(exp_stall));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_zero();
      m_cnt = 0;
    end else if (hold) begin
      // registers keep their contents
    end else begin
      if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (flush || lu) begin
        model_zero();
      end else begin
        m_valid = 1; m_ctrl = ctrl_in; m_pc = IF_ID_pc_add_out;
        m_r1 = regfile_out1; m_r2 = regfile_out2; m_ext = ext;
        m_rs = field(IF_ID_instr, 21, 31); m_rt = field(IF_ID_instr, 16, 31);
        m_rd = field(IF_ID_instr, 11, 31); m_funct = field(IF_ID_instr, 0, 63);
      end
    end
    check_outputs(tag);
  endtask

  task automatic drive(input logic r, input logic h, input logic f, input logic [31:0] instr,
                       input logic [7:0] c);
    rst_n = r; hold = h; flush = f; IF_ID_instr = instr; ctrl_in = c;
    IF_ID_pc_add_out = $urandom; regfile_out1 = $urandom;
    regfile_out2 = $urandom; ext = $urandom;
  endtask

  localparam logic [31:0] ADD_8_9_10 = 32'h012A_4020;
  localparam logic [31:0] LW_8       = 32'h8C08_0000;
  localparam logic [31:0] ADD_9_8_8  = 32'h0108_4820;
  localparam logic [31:0] LW_0       = 32'h8C00_0000;
  localparam logic [31:0] ADD_9_0_0  = 32'h0000_4820;
  localparam logic [7:0]  C_RTYPE    = 8'h09;
  localparam logic [7:0]  C_LW       = 8'h1E;

  initial begin
    logic [31:0] saved_pc, saved_r1;
    logic [7:0]  saved_ctrl;
    logic [31:0] instr;
    logic [7:0]  c;
    checks = 0;
    failures = 0;

    drive(1'b0, 1'b1, 1'b1, ADD_8_9_10, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    model_zero();
    m_cnt = 0;
    check_outputs("reset");
    check("reset.stall", 64'(stall), 64'd0);

    // Normal add
    drive(1'b1, 1'b0, 1'b0, ADD_8_9_10, C_RTYPE);
    step("normal");
    check("normal.rs", 64'(ID_EX_rs), 64'd9);
    check("normal.rt", 64'(ID_EX_rt), 64'd10);
    check("normal.rd", 64'(ID_EX_rd), 64'd8);
    check("normal.funct", 64'(ID_EX_funct), 64'h20);
    check("normal.valid", 64'(ID_EX_valid), 64'd1);

    // Load-use: one stall, one bubble, then the dependent add
    drive(1'b1, 1'b0, 1'b0, LW_8, C_LW);
    step("lu.lw");
    drive(1'b1, 1'b0, 1'b0, ADD_9_8_8, C_RTYPE);
    #1;
    check("lu.stall_on", 64'(stall), 64'd1);
    step("lu.bubble");
    check("lu.bubble_valid", 64'(ID_EX_valid), 64'd0);
    check("lu.stall_off", 64'(stall), 64'd0);
    step("lu.add");
    check("lu.add_valid", 64'(ID_EX_valid), 64'd1);
    check("lu.add_rd", 64'(ID_EX_rd), 64'd9);

    // $0 load never stalls
    drive(1'b1, 1'b0, 1'b0, LW_0, C_LW);
    step("zero.lw");
    drive(1'b1, 1'b0, 1'b0, ADD_9_0_0, C_RTYPE);
    #1;
    check("zero.stall", 64'(stall), 64'd0);
    step("zero.add");
    check("zero.valid", 64'(ID_EX_valid), 64'd1);

    // Flush together with a load-use hazard
    drive(1'b1, 1'b0, 1'b0, LW_8, C_LW);
    step("fl.lw");
    drive(1'b1, 1'b0, 1'b1, ADD_9_8_8, C_RTYPE);
    #1;
    check("fl.stall", 64'(stall), 64'd0);
    step("fl.bubble");
    check("fl.valid", 64'(ID_EX_valid), 64'd0);
    check("fl.ctrl", 64'(ID_EX_ctrl), 64'd0);

    // Hold for three cycles
    drive(1'b1, 1'b0, 1'b0, ADD_8_9_10, C_RTYPE);
    step("hold.pre");
    saved_pc = ID_EX_pc_add_out;
    saved_r1 = ID_EX_regfile_out1;
    saved_ctrl = ID_EX_ctrl;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom, 8'($urandom));
      step("hold");
      check("hold.pc_const", 64'(ID_EX_pc_add_out), 64'(saved_pc));
      check("hold.r1_const", 64'(ID_EX_regfile_out1), 64'(saved_r1));
      check("hold.ctrl_const", 64'(ID_EX_ctrl), 64'(saved_ctrl));
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0000, 8'h41);
    step("hold.release");
    check("hold.release_pc", 64'(ID_EX_pc_add_out), 64'(IF_ID_pc_add_out));

    // Reset mid-operation overrides hold
    drive(1'b0, 1'b1, 1'b0, LW_8, C_LW);
    step("rst_mid");
    check("rst_mid.valid", 64'(ID_EX_valid), 64'd0);

    // Randomized traffic with a narrow register range to provoke hazards
    for (int n = 0; n < 600; n++) begin
      instr = $urandom;
      instr[25:21] = 5'($urandom_range(0, 3));
      instr[20:16] = 5'($urandom_range(0, 3));
      c = 8'($urandom);
      if ($urandom_range(0, 1) == 0) c[4] = 1'b1;
      drive(($urandom_range(0, 40) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 6) == 0), instr, c);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
